// File: rtl/int_ctrl.sv
// Memory-mapped interrupt controller: latches edge/level requests, masks them and serves one at a
// time on hwint_o with an acknowledge cycle. Define INTC_SYNC_EN to add a 2-flop input synchronizer.
module int_ctrl #(
    parameter int unsigned NUM_SRC   = 6,
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F40,
    parameter logic [31:0] ACK_ADDR  = 32'h0000_7F20
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NUM_SRC-1:0] irq_src_i,
    input  logic [31:0]        bus_addr_i,
    input  logic [3:0]         bus_byteen_i,
    input  logic [31:0]        bus_wdata_i,
    output logic [31:0]        bus_rdata_o,
    output logic [NUM_SRC-1:0] hwint_o,
    input  logic               response_i,
    output logic [31:0]        ack_addr_o,
    output logic [3:0]         ack_byteen_o
);

    localparam int unsigned IdxW = 3;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAssert = 2'd1,
        StAck    = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [IdxW-1:0]    served_idx_q, served_idx_d;
    logic [NUM_SRC-1:0] hwint_q, hwint_d;
    logic [NUM_SRC-1:0] pend_q, pend_d;
    logic [NUM_SRC-1:0] mask_q, mask_d;
    logic [NUM_SRC-1:0] mode_q, mode_d;
    logic [NUM_SRC-1:0] irq_q;
    logic [NUM_SRC-1:0] irq_in;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] clr;
    logic [NUM_SRC-1:0] req;
    logic [NUM_SRC-1:0] served_oh;
    logic [IdxW-1:0]    low_idx;
    logic               in_win;
    logic               wr_en;
    logic               wr_pend;
    logic               wr_mask;
    logic               wr_mode;
    logic               unused_bus;

`ifdef INTC_SYNC_EN
    logic [NUM_SRC-1:0] sync1_q, sync2_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= irq_src_i;
            sync2_q <= sync1_q;
        end
    end

    assign irq_in = sync2_q;
`else
    assign irq_in = irq_src_i;
`endif

    // Only byte lane 0 carries register bits; the rest of the bus is deliberately ignored.
    assign unused_bus = ^{bus_wdata_i[31:NUM_SRC], bus_byteen_i[3:1], bus_addr_i[1:0]};

    assign in_win  = (bus_addr_i[31:4] == BASE_ADDR[31:4]);
    assign wr_en   = in_win && bus_byteen_i[0];
    assign wr_pend = wr_en && (bus_addr_i[3:2] == 2'd0);
    assign wr_mask = wr_en && (bus_addr_i[3:2] == 2'd1);
    assign wr_mode = wr_en && (bus_addr_i[3:2] == 2'd2);

    assign rise      = irq_in & ~irq_q;
    assign req       = pend_q & mask_q;
    assign served_oh = NUM_SRC'(1) << served_idx_q;

    always_comb begin
        low_idx = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                low_idx = IdxW'(i);
            end
        end
    end

    always_comb begin
        mask_d = wr_mask ? bus_wdata_i[NUM_SRC-1:0] : mask_q;
        mode_d = wr_mode ? bus_wdata_i[NUM_SRC-1:0] : mode_q;
    end

    // Edge bits: a new rising edge beats any clear (software W1C or acknowledge) in the same cycle.
    always_comb begin
        pend_d = pend_q;
        clr    = '0;
        if (wr_pend) begin
            clr = bus_wdata_i[NUM_SRC-1:0];
        end
        if ((state_q == StAssert) && response_i) begin
            clr = clr | served_oh;
        end
        for (int i = 0; i < NUM_SRC; i++) begin
            if (mode_q[i]) begin
                pend_d[i] = rise[i] | (pend_q[i] & ~clr[i]);
            end else begin
                pend_d[i] = irq_in[i];
            end
        end
    end

    // Withdrawal is judged on next-cycle PEND/MASK so hwint drops on the edge of the mask write.
    always_comb begin
        state_d      = state_q;
        served_idx_d = served_idx_q;
        hwint_d      = hwint_q;
        unique case (state_q)
            StIdle: begin
                if (|req) begin
                    served_idx_d = low_idx;
                    hwint_d      = NUM_SRC'(1) << low_idx;
                    state_d      = StAssert;
                end
            end
            StAssert: begin
                if (response_i) begin
                    hwint_d = '0;
                    state_d = StAck;
                end else if (!(|(pend_d & mask_d & served_oh))) begin
                    hwint_d = '0;
                    state_d = StIdle;
                end
            end
            StAck: begin
                hwint_d = '0;
                state_d = StIdle;
            end
            default: begin
                hwint_d = '0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            served_idx_q <= '0;
            hwint_q      <= '0;
            pend_q       <= '0;
            mask_q       <= '0;
            mode_q       <= '1;
            irq_q        <= '0;
        end else begin
            state_q      <= state_d;
            served_idx_q <= served_idx_d;
            hwint_q      <= hwint_d;
            pend_q       <= pend_d;
            mask_q       <= mask_d;
            mode_q       <= mode_d;
            irq_q        <= irq_in;
        end
    end

    always_comb begin
        bus_rdata_o = '0;
        if (in_win) begin
            unique case (bus_addr_i[3:2])
                2'd0: bus_rdata_o[NUM_SRC-1:0] = pend_q;
                2'd1: bus_rdata_o[NUM_SRC-1:0] = mask_q;
                2'd2: bus_rdata_o[NUM_SRC-1:0] = mode_q;
                2'd3: bus_rdata_o[5:0]         = {state_q, 1'b0, served_idx_q};
                default: bus_rdata_o = '0;
            endcase
        end
    end

    assign hwint_o      = hwint_q;
    assign ack_addr_o   = (state_q == StAck) ? ACK_ADDR : 32'h0;
    assign ack_byteen_o = (state_q == StAck) ? 4'b0001 : 4'b0000;

endmodule

// File: tb/tb_int_ctrl.sv
// Self-checking bench for int_ctrl: register table, directed corner sequences and a randomized
// run against a cycle-level reference model.
module tb_int_ctrl;

    localparam logic [31:0] Base = 32'h0000_7F40;
    localparam logic [31:0] AckA = 32'h0000_7F20;
`ifdef INTC_SYNC_EN
    localparam int SyncLat = 2;
`else
    localparam int SyncLat = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  irq_src;
    logic [31:0] bus_addr;
    logic [3:0]  bus_byteen;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic [5:0]  hwint;
    logic        response;
    logic [31:0] ack_addr;
    logic [3:0]  ack_byteen;

    int n_err = 0;
    int n_chk = 0;

    always #5 clk = ~clk;

    int_ctrl dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .irq_src_i    (irq_src),
        .bus_addr_i   (bus_addr),
        .bus_byteen_i (bus_byteen),
        .bus_wdata_i  (bus_wdata),
        .bus_rdata_o  (bus_rdata),
        .hwint_o      (hwint),
        .response_i   (response),
        .ack_addr_o   (ack_addr),
        .ack_byteen_o (ack_byteen)
    );

    typedef struct {
        logic [31:0] waddr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] raddr;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [15];

    // Reference model state
    logic [5:0] m_pend, m_mask, m_mode, m_prev, m_s1, m_s2, m_hw;
    int         m_phase, m_idx;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        bus_addr   = a;
        bus_wdata  = d;
        bus_byteen = be;
        tick();
        bus_byteen = 4'h0;
    endtask

    task automatic read_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
        bus_addr   = a;
        bus_byteen = 4'h0;
        #1;
        check(name, bus_rdata, exp);
    endtask

    task automatic model_reset();
        m_pend = '0; m_mask = '0; m_mode = 6'h3F; m_prev = '0;
        m_s1 = '0; m_s2 = '0; m_hw = '0; m_phase = 0; m_idx = 0;
    endtask

    function automatic logic [31:0] model_rdata(input logic [31:0] a);
        logic [31:0] r;
        logic [1:0]  ph;
        logic [2:0]  ix;
        r  = '0;
        ph = m_phase[1:0];
        ix = m_idx[2:0];
        if (a[31:4] == Base[31:4]) begin
            case (a[3:2])
                2'd0: r[5:0] = m_pend;
                2'd1: r[5:0] = m_mask;
                2'd2: r[5:0] = m_mode;
                default: r[5:0] = {ph, 1'b0, ix};
            endcase
        end
        return r;
    endfunction

    // One clock edge of the controller, derived from the behavioural rules.
    task automatic model_step(input logic [5:0] irq, input logic resp, input logic [31:0] a,
                              input logic [3:0] be, input logic [31:0] wd);
        logic [5:0] in_v, np, nm, nmode;
        logic       wr, clr;
        int         lo;
        in_v  = (SyncLat != 0) ? m_s2 : irq;
        wr    = (a[31:4] == Base[31:4]) && be[0];
        nm    = (wr && a[3:2] == 2'd1) ? wd[5:0] : m_mask;
        nmode = (wr && a[3:2] == 2'd2) ? wd[5:0] : m_mode;
        for (int i = 0; i < 6; i++) begin
            if (m_mode[i]) begin
                clr = (wr && a[3:2] == 2'd0 && wd[i]) || (m_phase == 1 && resp && m_idx == i);
                if (in_v[i] && !m_prev[i]) np[i] = 1'b1;
                else if (clr)              np[i] = 1'b0;
                else                       np[i] = m_pend[i];
            end else begin
                np[i] = in_v[i];
            end
        end
        if (m_phase == 0) begin
            lo = -1;
            for (int i = 5; i >= 0; i--) if (m_pend[i] && m_mask[i]) lo = i;
            if (lo >= 0) begin
                m_phase = 1;
                m_idx   = lo;
                m_hw    = 6'h01 << lo;
            end
        end else if (m_phase == 1) begin
            if (resp) begin
                m_phase = 2;
                m_hw    = '0;
            end else if (!(np[m_idx] && nm[m_idx])) begin
                m_phase = 0;
                m_hw    = '0;
            end
        end else begin
            m_phase = 0;
        end
        m_pend = np;
        m_mask = nm;
        m_mode = nmode;
        m_prev = in_v;
        m_s2   = m_s1;
        m_s1   = irq;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; irq_src = '0; bus_addr = '0; bus_byteen = '0; bus_wdata = '0;
        response = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        check("rst_hwint", 32'(hwint), 32'h0);
        check("rst_ack_addr", ack_addr, 32'h0);
        check("rst_ack_be", 32'(ack_byteen), 32'h0);

        // Register table: be==0 rows are pure reads
        vecs[0]  = '{32'h0,      4'h0, 32'h0,        32'h7F40,     32'h0};
        vecs[1]  = '{32'h0,      4'h0, 32'h0,        32'h7F44,     32'h0};
        vecs[2]  = '{32'h0,      4'h0, 32'h0,        32'h7F48,     32'h3F};
        vecs[3]  = '{32'h0,      4'h0, 32'h0,        32'h7F4C,     32'h0};
        vecs[4]  = '{32'h0,      4'h0, 32'h0,        32'h7F50,     32'h0};
        vecs[5]  = '{32'h0,      4'h0, 32'h0,        32'h7F3C,     32'h0};
        vecs[6]  = '{32'h0,      4'h0, 32'h0,        32'h0000_0048, 32'h0};
        vecs[7]  = '{32'h7F44,   4'h1, 32'hFFFF_FFFF, 32'h7F44,    32'h3F};
        vecs[8]  = '{32'h7F44,   4'hE, 32'h0,        32'h7F44,     32'h3F};
        vecs[9]  = '{32'h7F48,   4'h1, 32'h2A,       32'h7F48,     32'h2A};
        vecs[10] = '{32'h7F54,   4'h1, 32'h0,        32'h7F44,     32'h3F};
        vecs[11] = '{32'h7F4C,   4'h1, 32'hFF,       32'h7F4C,     32'h0};
        vecs[12] = '{32'h7F40,   4'h1, 32'h3F,       32'h7F40,     32'h0};
        vecs[13] = '{32'h7F48,   4'hF, 32'hFFFF_FFFF, 32'h7F48,    32'h3F};
        vecs[14] = '{32'h7F44,   4'h3, 32'h0000_0100, 32'h7F44,    32'h0};
        tick();
        for (int v = 0; v < 15; v++) begin
            if (vecs[v].be != 4'h0) bus_write(vecs[v].waddr, vecs[v].wdata, vecs[v].be);
            read_chk($sformatf("table%0d", v), vecs[v].raddr, vecs[v].exp);
        end

        // Basic edge request, service and acknowledge
        bus_write(32'h7F44, 32'h07, 4'h1);
        irq_src = 6'h01;
        repeat (SyncLat) tick();
        tick();
        read_chk("a_pend", 32'h7F40, 32'h01);
        check("a_hwint_early", 32'(hwint), 32'h0);
        tick();
        check("a_hwint", 32'(hwint), 32'h01);
        read_chk("a_stat_assert", 32'h7F4C, 32'h10);
        tick(); tick();
        check("a_hwint_hold", 32'(hwint), 32'h01);
        response = 1'b1; tick(); response = 1'b0;
        check("a_ack_addr", ack_addr, AckA);
        check("a_ack_be", 32'(ack_byteen), 32'h1);
        check("a_hwint_ack", 32'(hwint), 32'h0);
        read_chk("a_pend_ack", 32'h7F40, 32'h0);
        read_chk("a_stat_ack", 32'h7F4C, 32'h20);
        tick();
        check("a_ack_end", 32'(ack_byteen), 32'h0);
        irq_src = 6'h00;
        repeat (SyncLat + 1) tick();

        // Simultaneous sources: lowest index first, next one two cycles after ACK
        bus_write(32'h7F44, 32'h05, 4'h1);
        irq_src = 6'h05;
        repeat (SyncLat) tick();
        tick();
        read_chk("b_pend", 32'h7F40, 32'h05);
        tick();
        check("b_hwint_first", 32'(hwint), 32'h01);
        response = 1'b1; tick(); response = 1'b0;
        check("b_ack_be", 32'(ack_byteen), 32'h1);
        read_chk("b_pend_ack", 32'h7F40, 32'h04);
        tick();
        check("b_gap", 32'(hwint), 32'h0);
        tick();
        check("b_hwint_second", 32'(hwint), 32'h04);
        response = 1'b1; tick(); response = 1'b0;
        tick();
        irq_src = 6'h00;
        repeat (SyncLat + 1) tick();

        // Masking while asserted withdraws the request but keeps it pending
        bus_write(32'h7F44, 32'h07, 4'h1);
        irq_src = 6'h02;
        repeat (SyncLat) tick();
        tick(); tick();
        check("c_hwint", 32'(hwint), 32'h02);
        bus_write(32'h7F44, 32'h00, 4'h1);
        check("c_hwint_masked", 32'(hwint), 32'h0);
        read_chk("c_stat", 32'h7F4C, 32'h01);
        read_chk("c_pend_kept", 32'h7F40, 32'h02);
        bus_write(32'h7F40, 32'h02, 4'h1);
        read_chk("c_pend_w1c", 32'h7F40, 32'h0);
        irq_src = 6'h00;
        repeat (SyncLat + 1) tick();

        // Level mode: follows the source, ignores W1C and is re-served after ACK
        bus_write(32'h7F48, 32'h00, 4'h1);
        bus_write(32'h7F44, 32'h04, 4'h1);
        irq_src = 6'h04;
        repeat (SyncLat) tick();
        tick();
        read_chk("d_pend", 32'h7F40, 32'h04);
        tick();
        check("d_hwint", 32'(hwint), 32'h04);
        response = 1'b1; tick(); response = 1'b0;
        check("d_ack_be", 32'(ack_byteen), 32'h1);
        read_chk("d_pend_ack", 32'h7F40, 32'h04);
        tick(); tick();
        check("d_reserved", 32'(hwint), 32'h04);
        bus_write(32'h7F40, 32'h04, 4'h1);
        read_chk("d_w1c_noeffect", 32'h7F40, 32'h04);
        check("d_hwint_w1c", 32'(hwint), 32'h04);
        irq_src = 6'h00;
        repeat (SyncLat) tick();
        tick();
        read_chk("d_pend_drop", 32'h7F40, 32'h0);
        check("d_hwint_drop", 32'(hwint), 32'h0);
        bus_write(32'h7F48, 32'h3F, 4'h1);
        bus_write(32'h7F44, 32'h00, 4'h1);

        // Set beats W1C on the same edge
        irq_src = 6'h01;
        repeat (SyncLat) tick();
        tick();
        irq_src = 6'h00;
        repeat (SyncLat) tick();
        tick();
        read_chk("e_pend_held", 32'h7F40, 32'h01);
        irq_src = 6'h01;
        repeat (SyncLat) tick();
        bus_write(32'h7F40, 32'h01, 4'h1);
        read_chk("e_collision", 32'h7F40, 32'h01);
        bus_write(32'h7F40, 32'h01, 4'h1);
        read_chk("e_w1c", 32'h7F40, 32'h0);
        read_chk("e_stat", 32'h7F4C, 32'h02);
        irq_src = 6'h00;
        repeat (SyncLat + 1) tick();

        // Asynchronous reset during ACK, then during ASSERT
        bus_write(32'h7F44, 32'h01, 4'h1);
        irq_src = 6'h01;
        repeat (SyncLat) tick();
        tick(); tick();
        response = 1'b1; tick(); response = 1'b0;
        check("f_ack_before", 32'(ack_byteen), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("f_ack_addr_rst", ack_addr, 32'h0);
        check("f_ack_be_rst", 32'(ack_byteen), 32'h0);
        irq_src = 6'h00;
        @(posedge clk);
        #2 rst_n = 1'b1;
        tick();
        bus_write(32'h7F44, 32'h01, 4'h1);
        irq_src = 6'h01;
        repeat (SyncLat) tick();
        tick(); tick();
        check("f_hwint_before", 32'(hwint), 32'h01);
        #2 rst_n = 1'b0;
        #1;
        check("f_hwint_rst", 32'(hwint), 32'h0);
        check("f_ack_be_assert_rst", 32'(ack_byteen), 32'h0);
        irq_src = 6'h00;
        @(posedge clk);
        #2 rst_n = 1'b1;
        read_chk("f_mask", 32'h7F44, 32'h0);
        read_chk("f_pend", 32'h7F40, 32'h0);
        read_chk("f_mode", 32'h7F48, 32'h3F);
        tick();

        // Randomized run against the reference model
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            int r;
            for (int b = 0; b < 6; b++) if ($urandom % 8 == 0) irq_src[b] = ~irq_src[b];
            response = ($urandom % 3 == 0);
            r = $urandom % 8;
            if (r < 3) begin
                bus_addr   = Base + 32'(4 * ($urandom % 4));
                bus_byteen = 4'($urandom % 16);
                bus_wdata  = $urandom;
            end else if (r == 3) begin
                bus_addr   = 32'h7F50 + 32'(4 * ($urandom % 4));
                bus_byteen = 4'hF;
                bus_wdata  = $urandom;
            end else begin
                bus_addr   = Base + 32'(4 * ($urandom % 4));
                bus_byteen = 4'h0;
            end
            @(negedge clk);
            check("rand_hwint", 32'(hwint), 32'(m_hw));
            check("rand_rdata", bus_rdata, model_rdata(bus_addr));
            check("rand_ack_addr", ack_addr, (m_phase == 2) ? AckA : 32'h0);
            check("rand_ack_be", 32'(ack_byteen), (m_phase == 2) ? 32'h1 : 32'h0);
            @(posedge clk);
            model_step(irq_src, response, bus_addr, bus_byteen, bus_wdata);
            #1;
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
